// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard.
//   REG_ADDR_W  : register-file address width
//   ZERO_REG    : hard-wired zero register, never a real writer
//   slot_t      : per-stage record {reg_write, mem_to_reg, dest}
//   SLOT_BUBBLE : the empty record loaded on bubbles, flushes and reset
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] dest;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, dest: ZERO_REG};

endpackage

// File: rtl/hazard_slot_match.sv
// Combinational dependency check of one in-flight slot against the
// operands read by the instruction currently in ID.
// Ports:
//   slot    : in-flight record (EX or MEM stage)
//   uses_rs : ID instruction reads rs
//   uses_rt : ID instruction reads rt
//   rs, rt  : ID source register fields
//   match   : slot writes a register (other than $0) that ID reads
module hazard_slot_match
  import hazard_scoreboard_pkg::*;
(
  input  slot_t                 slot,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  match
);

  always_comb begin
    match = slot.reg_write & (slot.dest != ZERO_REG) &
            ((uses_rs & (slot.dest == rs)) | (uses_rt & (slot.dest == rt)));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline. Shifts the destination
// records of in-flight instructions through EX, MEM and WB slots, reports
// the MEM/WB slots to the forwarding unit, and stalls the front end on the
// hazards forwarding cannot cover (load-use, branch-in-ID dependencies).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   id_*                       : fields of the instruction currently in ID
//   flush                      : discard the ID instruction
//   pc_write_en/if_id_write_en : 0 holds PC / IF-ID during a stall
//   id_ex_bubble               : 1 inserts a NOP into ID/EX
//   ex_mem_*/mem_wb_*          : registered write-back indications
//   stall_cycles               : saturating count of stalled cycles
//
// Control contract: a stall freezes PC and IF/ID for that cycle and
// injects a bubble into ID/EX; the held ID instruction is re-evaluated
// next cycle. flush overrides stall and also injects a bubble.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = hazard_scoreboard_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_instr_rs,
  input  logic [REG_ADDR_W-1:0] id_instr_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] id_write_reg_addr,
  input  logic                  flush,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_reg_write,
  output logic [REG_ADDR_W-1:0] ex_mem_write_reg_addr,
  output logic                  mem_wb_reg_write,
  output logic [REG_ADDR_W-1:0] mem_wb_write_reg_addr,
  output logic [CNT_W-1:0]      stall_cycles
);

  import hazard_scoreboard_pkg::*;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic  match_ex, match_mem;
  logic  load_use, br_ex, br_mem, stall;

  hazard_slot_match u_match_ex (
    .slot    (ex_q),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .rs      (id_instr_rs),
    .rt      (id_instr_rt),
    .match   (match_ex)
  );

  hazard_slot_match u_match_mem (
    .slot    (mem_q),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .rs      (id_instr_rs),
    .rt      (id_instr_rt),
    .match   (match_mem)
  );

  always_comb begin
    load_use = match_ex & ex_q.mem_to_reg;
    // A branch compares in ID, so even an ALU result in EX is too late.
    br_ex    = id_is_branch & match_ex;
    br_mem   = id_is_branch & match_mem & mem_q.mem_to_reg;
    stall    = id_valid & ~flush & (load_use | br_ex | br_mem);

    pc_write_en    = ~stall;
    if_id_write_en = ~stall;
    id_ex_bubble   = stall | flush;

    // Writes to $0 are dropped on entry so they are never reported downstream.
    ex_d = SLOT_BUBBLE;
    if (id_valid & ~stall & ~flush) begin
      ex_d.reg_write  = id_reg_write & (id_write_reg_addr != ZERO_REG);
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.dest       = id_write_reg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= SLOT_BUBBLE;
      mem_q        <= SLOT_BUBBLE;
      wb_q         <= SLOT_BUBBLE;
      stall_cycles <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ex_mem_reg_write      = mem_q.reg_write;
    ex_mem_write_reg_addr = mem_q.dest;
    mem_wb_reg_write      = wb_q.reg_write;
    mem_wb_write_reg_addr = wb_q.dest;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table of ID instructions with
// expected stall/bubble, hand sequences for reset, and random traffic,
// all checked against an age-indexed model of in-flight instructions.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_instr_rs, id_instr_rt;
  logic          id_uses_rs, id_uses_rt, id_is_branch;
  logic          id_reg_write, id_mem_to_reg;
  logic [AW-1:0] id_write_reg_addr;
  logic          flush;
  logic          pc_write_en, if_id_write_en, id_ex_bubble;
  logic          ex_mem_reg_write, mem_wb_reg_write;
  logic [AW-1:0] ex_mem_write_reg_addr, mem_wb_write_reg_addr;
  logic [CW-1:0] stall_cycles;

  hazard_scoreboard #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .id_valid              (id_valid),
    .id_instr_rs           (id_instr_rs),
    .id_instr_rt           (id_instr_rt),
    .id_uses_rs            (id_uses_rs),
    .id_uses_rt            (id_uses_rt),
    .id_is_branch          (id_is_branch),
    .id_reg_write          (id_reg_write),
    .id_mem_to_reg         (id_mem_to_reg),
    .id_write_reg_addr     (id_write_reg_addr),
    .flush                 (flush),
    .pc_write_en           (pc_write_en),
    .if_id_write_en        (if_id_write_en),
    .id_ex_bubble          (id_ex_bubble),
    .ex_mem_reg_write      (ex_mem_reg_write),
    .ex_mem_write_reg_addr (ex_mem_write_reg_addr),
    .mem_wb_reg_write      (mem_wb_reg_write),
    .mem_wb_write_reg_addr (mem_wb_write_reg_addr),
    .stall_cycles          (stall_cycles)
  );

  // ---------------- vectors ----------------
  typedef struct {
    bit          valid;
    bit [AW-1:0] rs;
    bit [AW-1:0] rt;
    bit          urs;
    bit          urt;
    bit          br;
    bit          rw;
    bit          ld;
    bit [AW-1:0] wa;
    bit          fl;
    bit          use_exp;   // table carries explicit expectations
    bit          exp_stall;
    bit          exp_bubble;
  } vec_t;

  // ---------------- reference model ----------------
  // age[0] is the most recently accepted instruction (EX), age[1] the one
  // before (MEM), age[2] the oldest still tracked (WB).
  typedef struct {
    bit          rw;
    bit          ld;
    bit [AW-1:0] dest;
  } rec_t;

  rec_t          age [3];
  logic [CW-1:0] exp_cnt;

  function automatic bit reads_reg(vec_t v, bit [AW-1:0] r);
    return (r != 0) && ((v.urs && v.rs == r) || (v.urt && v.rt == r));
  endfunction

  function automatic bit depends_on(vec_t v, int k);
    return age[k].rw && reads_reg(v, age[k].dest);
  endfunction

  // Stall when the needed value is not yet producible in time:
  // a load one ahead of any reader, anything one ahead of a branch,
  // a load two ahead of a branch.
  function automatic bit model_stall(vec_t v);
    if (!v.valid || v.fl) return 1'b0;
    return (depends_on(v, 0) && (age[0].ld || v.br)) ||
           (v.br && depends_on(v, 1) && age[1].ld);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) age[k] = '{rw: 1'b0, ld: 1'b0, dest: '0};
    exp_cnt = '0;
  endtask

  task automatic model_edge(vec_t v, bit rst);
    bit s;
    s = model_stall(v);
    if (rst) begin
      model_clear();
    end else begin
      age[2] = age[1];
      age[1] = age[0];
      if (v.valid && !s && !v.fl)
        age[0] = '{rw: v.rw && (v.wa != 0), ld: v.ld, dest: v.wa};
      else
        age[0] = '{rw: 1'b0, ld: 1'b0, dest: '0};
      if (s && exp_cnt != '1) exp_cnt = exp_cnt + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive(vec_t v);
    id_valid          = v.valid;
    id_instr_rs       = v.rs;
    id_instr_rt       = v.rt;
    id_uses_rs        = v.urs;
    id_uses_rt        = v.urt;
    id_is_branch      = v.br;
    id_reg_write      = v.rw;
    id_mem_to_reg     = v.ld;
    id_write_reg_addr = v.wa;
    flush             = v.fl;
  endtask

  // One pipeline cycle: apply, check mid-cycle, clock, advance model.
  task automatic cycle(vec_t v, bit rst, string tag);
    bit s;
    reset = rst;
    drive(v);
    @(negedge clk);
    s = model_stall(v);
    chk({tag, ".pc_write_en"},    32'(pc_write_en),    32'(!s));
    chk({tag, ".if_id_write_en"}, 32'(if_id_write_en), 32'(!s));
    chk({tag, ".id_ex_bubble"},   32'(id_ex_bubble),   32'(s || (v.valid && v.fl) || v.fl));
    chk({tag, ".ex_mem_rw"},      32'(ex_mem_reg_write),      32'(age[1].rw));
    chk({tag, ".ex_mem_addr"},    32'(ex_mem_write_reg_addr), 32'(age[1].dest));
    chk({tag, ".mem_wb_rw"},      32'(mem_wb_reg_write),      32'(age[2].rw));
    chk({tag, ".mem_wb_addr"},    32'(mem_wb_write_reg_addr), 32'(age[2].dest));
    chk({tag, ".stall_cycles"},   stall_cycles,               exp_cnt);
    if (v.use_exp) begin
      chk({tag, ".tbl_stall"},  32'(!pc_write_en), 32'(v.exp_stall));
      chk({tag, ".tbl_bubble"}, 32'(id_ex_bubble), 32'(v.exp_bubble));
    end
    @(posedge clk);
    model_edge(v, rst);
    #1;
  endtask

  function automatic vec_t mk(bit valid, bit [AW-1:0] rs, bit [AW-1:0] rt, bit urs, bit urt,
                              bit br, bit rw, bit ld, bit [AW-1:0] wa, bit fl,
                              bit es, bit eb);
    vec_t v;
    v = '{valid: valid, rs: rs, rt: rt, urs: urs, urt: urt, br: br, rw: rw, ld: ld,
          wa: wa, fl: fl, use_exp: 1'b1, exp_stall: es, exp_bubble: eb};
    return v;
  endfunction

  vec_t tbl [18];
  vec_t v;

  initial begin
    // ---- directed table ----
    //            vld rs  rt  urs urt br rw ld wa  fl  stall bub
    tbl[0]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  0,  0, 0);  // idle
    tbl[1]  = mk(1, 29, 0,  1, 0, 0, 1, 1, 8,  0,  0, 0);  // lw $8
    tbl[2]  = mk(1, 8,  10, 1, 1, 0, 1, 0, 11, 0,  1, 1);  // add uses $8: load-use
    tbl[3]  = mk(1, 8,  10, 1, 1, 0, 1, 0, 11, 0,  0, 0);  // add proceeds
    tbl[4]  = mk(1, 1,  2,  1, 1, 0, 1, 0, 9,  0,  0, 0);  // add $9
    tbl[5]  = mk(1, 9,  3,  1, 1, 1, 0, 0, 0,  0,  1, 1);  // beq rs=9: br_ex
    tbl[6]  = mk(1, 9,  3,  1, 1, 1, 0, 0, 0,  0,  0, 0);  // beq proceeds
    tbl[7]  = mk(1, 29, 0,  1, 0, 0, 1, 1, 9,  0,  0, 0);  // lw $9
    tbl[8]  = mk(1, 4,  9,  1, 1, 1, 0, 0, 0,  0,  1, 1);  // beq rt=9: br_ex
    tbl[9]  = mk(1, 4,  9,  1, 1, 1, 0, 0, 0,  0,  1, 1);  // beq: br_mem
    tbl[10] = mk(1, 4,  9,  1, 1, 1, 0, 0, 0,  0,  0, 0);  // beq proceeds
    tbl[11] = mk(1, 29, 0,  1, 0, 0, 1, 1, 0,  0,  0, 0);  // lw $0
    tbl[12] = mk(1, 0,  0,  1, 0, 0, 1, 0, 12, 0,  0, 0);  // add reads $0: no stall
    tbl[13] = mk(1, 29, 0,  1, 0, 0, 1, 1, 8,  0,  0, 0);  // lw $8
    tbl[14] = mk(1, 8,  5,  0, 1, 0, 1, 0, 13, 0,  0, 0);  // rs=8 unused: no stall
    tbl[15] = mk(1, 29, 0,  1, 0, 0, 1, 1, 8,  0,  0, 0);  // lw $8
    tbl[16] = mk(1, 8,  0,  1, 0, 0, 1, 0, 14, 1,  0, 1);  // dependent add flushed
    tbl[17] = mk(1, 8,  0,  1, 0, 0, 1, 0, 14, 0,  0, 0);  // flushed slot is a bubble

    // ---- reset held two edges with a valid ID instruction ----
    model_clear();
    reset = 1'b1;
    drive(tbl[2]);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.pc_write_en",    32'(pc_write_en),           32'd1);
    chk("rst.if_id_write_en", 32'(if_id_write_en),        32'd1);
    chk("rst.id_ex_bubble",   32'(id_ex_bubble),          32'd0);
    chk("rst.ex_mem_rw",      32'(ex_mem_reg_write),      32'd0);
    chk("rst.ex_mem_addr",    32'(ex_mem_write_reg_addr), 32'd0);
    chk("rst.mem_wb_rw",      32'(mem_wb_reg_write),      32'd0);
    chk("rst.mem_wb_addr",    32'(mem_wb_write_reg_addr), 32'd0);
    chk("rst.stall_cycles",   stall_cycles,               32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) cycle(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Load-use latency: lw $8 reaches ex_mem then mem_wb on later edges.
    cycle(tbl[1], 1'b0, "lat.lw");
    cycle(tbl[2], 1'b0, "lat.stall");
    chk("lat.ex_mem_addr", 32'(ex_mem_write_reg_addr), 32'd8);
    cycle(tbl[3], 1'b0, "lat.add");
    chk("lat.mem_wb_addr", 32'(mem_wb_write_reg_addr), 32'd8);
    chk("lat.mem_wb_rw",   32'(mem_wb_reg_write),      32'd1);

    // ---- reset in the second stall cycle of lw/beq ----
    cycle(tbl[0], 1'b0, "mid.idle");
    cycle(tbl[7], 1'b0, "mid.lw");
    cycle(tbl[8], 1'b0, "mid.stall1");
    v = tbl[9];
    cycle(v, 1'b1, "mid.stall2_rst");
    v.exp_stall = 1'b0; v.exp_bubble = 1'b0;
    cycle(v, 1'b0, "mid.after");
    chk("mid.stall_cycles_zero", stall_cycles, 32'd0);

    // ---- random traffic ----
    for (int i = 0; i < 600; i++) begin
      v.valid   = ($urandom_range(0, 9) != 0);
      v.rs      = AW'($urandom_range(0, 3));
      v.rt      = AW'($urandom_range(0, 3));
      v.urs     = ($urandom_range(0, 3) != 0);
      v.urt     = $urandom_range(0, 1) == 1;
      v.br      = ($urandom_range(0, 9) < 3);
      v.rw      = v.br ? 1'b0 : ($urandom_range(0, 4) != 0);
      v.ld      = v.rw && ($urandom_range(0, 2) == 0);
      v.wa      = AW'($urandom_range(0, 3));
      v.fl      = ($urandom_range(0, 19) == 0);
      v.use_exp = 1'b0;
      v.exp_stall = 1'b0;
      v.exp_bubble = 1'b0;
      cycle(v, ($urandom_range(0, 99) == 0), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
